// File: rtl/craps_pkg.sv
// Shared types and constants for the craps scoring FSM.
package craps_pkg;

    typedef enum logic [1:0] {
        COME_OUT = 2'd0,
        POINT    = 2'd1,
        WIN      = 2'd2,
        LOSE     = 2'd3
    } state_t;

    localparam logic [3:0] SUM_TWO    = 4'd2;
    localparam logic [3:0] SUM_THREE  = 4'd3;
    localparam logic [3:0] SUM_SEVEN  = 4'd7;
    localparam logic [3:0] SUM_ELEVEN = 4'd11;
    localparam logic [3:0] SUM_TWELVE = 4'd12;
    localparam logic [3:0] NO_POINT   = 4'd0;

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser (SYNC_STAGES flops) followed by a rising-edge detector.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;

    // Shift the raw button in; remember the last synchronised level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
        edge_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge flops, cleared by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign pulse_out = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/craps_game_fsm.sv
// Craps game scorer: come-out roll, point phase, win/lose.
// Optional macro CRAPS_ROLL_COUNT_EN adds the roll_count output.
module craps_game_fsm
    import craps_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIE_MAX     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll,
    input  logic       new_game,
    input  logic [2:0] dice1_in,
    input  logic [2:0] dice2_in,
    output logic [3:0] sum_out,
    output logic [3:0] point_out,
    output logic [2:0] state_out,
    output logic       win,
    output logic       lose,
    output logic       bad_roll
`ifdef CRAPS_ROLL_COUNT_EN
    ,
    output logic [7:0] roll_count
`endif
);

    localparam logic [3:0] DIE_MAX_L = 4'(DIE_MAX);

    logic [1:0] rst_pipe_q, rst_pipe_d;
    logic       rst_int_n;
    logic       roll_pulse, new_game_pulse;
    logic       die_bad;
    logic [3:0] roll_sum;

    state_t     state_q, state_d;
    logic [3:0] sum_q, sum_d;
    logic [3:0] point_q, point_d;
    logic       win_q, win_d;
    logic       lose_q, lose_d;
    logic       bad_q, bad_d;
`ifdef CRAPS_ROLL_COUNT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    // Reset synchroniser: assert immediately, release after two clean edges.
    always_comb rst_pipe_d = {rst_pipe_q[0], 1'b1};

    // Reset synchroniser flops, cleared directly by the external reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe_q <= '0;
        else      rst_pipe_q <= rst_pipe_d;
    end

    assign rst_int_n = rst_pipe_q[1];

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_roll_sync (
        .clk       (clk),
        .rst       (rst_int_n),
        .btn_in    (roll),
        .pulse_out (roll_pulse)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_new_game_sync (
        .clk       (clk),
        .rst       (rst_int_n),
        .btn_in    (new_game),
        .pulse_out (new_game_pulse)
    );

    // Die validation and zero-extended sum of the sampled faces.
    always_comb begin
        die_bad  = (dice1_in == 3'd0) || (dice2_in == 3'd0) ||
                   ({1'b0, dice1_in} > DIE_MAX_L) || ({1'b0, dice2_in} > DIE_MAX_L);
        roll_sum = {1'b0, dice1_in} + {1'b0, dice2_in};
    end

    // Next-state logic; new_game takes priority and drops a coincident roll.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        point_d = point_q;
        bad_d   = 1'b0;
`ifdef CRAPS_ROLL_COUNT_EN
        cnt_d   = cnt_q;
`endif
        if (new_game_pulse) begin
            state_d = COME_OUT;
            sum_d   = '0;
            point_d = NO_POINT;
`ifdef CRAPS_ROLL_COUNT_EN
            cnt_d   = '0;
`endif
        end else if (roll_pulse && (state_q == COME_OUT || state_q == POINT)) begin
            if (die_bad) begin
                bad_d = 1'b1;
            end else begin
                sum_d = roll_sum;
`ifdef CRAPS_ROLL_COUNT_EN
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
                if (state_q == COME_OUT) begin
                    if (roll_sum == SUM_SEVEN || roll_sum == SUM_ELEVEN) begin
                        state_d = WIN;
                    end else if (roll_sum == SUM_TWO || roll_sum == SUM_THREE ||
                                 roll_sum == SUM_TWELVE) begin
                        state_d = LOSE;
                    end else begin
                        state_d = POINT;
                        point_d = roll_sum;
                    end
                end else begin
                    if (roll_sum == point_q)        state_d = WIN;
                    else if (roll_sum == SUM_SEVEN) state_d = LOSE;
                end
            end
        end
        win_d  = (state_d == WIN);
        lose_d = (state_d == LOSE);
    end

    // Game state registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= COME_OUT;
            sum_q   <= '0;
            point_q <= NO_POINT;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            bad_q   <= 1'b0;
`ifdef CRAPS_ROLL_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            point_q <= point_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            bad_q   <= bad_d;
`ifdef CRAPS_ROLL_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign sum_out   = sum_q;
    assign point_out = point_q;
    assign state_out = {1'b0, state_q};
    assign win       = win_q;
    assign lose      = lose_q;
    assign bad_roll  = bad_q;
`ifdef CRAPS_ROLL_COUNT_EN
    assign roll_count = cnt_q;
`endif

endmodule

// File: tb/tb_craps_game_fsm.sv
// Self-checking bench for craps_game_fsm: vector table plus scoreboard queue.
module tb_craps_game_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       roll;
    logic       new_game;
    logic [2:0] dice1_in;
    logic [2:0] dice2_in;
    logic [3:0] sum_out;
    logic [3:0] point_out;
    logic [2:0] state_out;
    logic       win;
    logic       lose;
    logic       bad_roll;
`ifdef CRAPS_ROLL_COUNT_EN
    logic [7:0] roll_count;
`endif

    craps_game_fsm #(.SYNC_STAGES(2), .DIE_MAX(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .roll      (roll),
        .new_game  (new_game),
        .dice1_in  (dice1_in),
        .dice2_in  (dice2_in),
        .sum_out   (sum_out),
        .point_out (point_out),
        .state_out (state_out),
        .win       (win),
        .lose      (lose),
        .bad_roll  (bad_roll)
`ifdef CRAPS_ROLL_COUNT_EN
        ,
        .roll_count(roll_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int point;
        int state;
        int bad;
        int cnt;
    } exp_t;

    typedef struct {
        bit   ng;
        int   d1;
        int   d2;
        exp_t e;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    function automatic exp_t mke(int sum, int point, int state, int bad, int cnt);
        exp_t e;
        e.sum = sum; e.point = point; e.state = state; e.bad = bad; e.cnt = cnt;
        return e;
    endfunction

    function automatic vec_t mkv(bit ng, int d1, int d2, exp_t e);
        vec_t v;
        v.ng = ng; v.d1 = d1; v.d2 = d2; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic compare_sb(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".sum"},   int'(sum_out),   e.sum);
            check({tag, ".point"}, int'(point_out), e.point);
            check({tag, ".state"}, int'(state_out), e.state);
            check({tag, ".win"},   int'(win),       (e.state == 2) ? 1 : 0);
            check({tag, ".lose"},  int'(lose),      (e.state == 3) ? 1 : 0);
            check({tag, ".bad"},   int'(bad_roll),  e.bad);
`ifdef CRAPS_ROLL_COUNT_EN
            check({tag, ".cnt"},   int'(roll_count), e.cnt);
`endif
        end
    endtask

    // Drive one roll or new_game press, then check two edges after the sync.
    task automatic apply_vec(input string tag, input vec_t v);
        @(negedge clk);
        dice1_in = 3'(v.d1);
        dice2_in = 3'(v.d2);
        if (v.ng) new_game = 1'b1;
        else      roll     = 1'b1;
        sb_q.push_back(v.e);
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_sb(tag);
        @(negedge clk);
        check({tag, ".bad_width"}, int'(bad_roll), 0);
        roll     = 1'b0;
        new_game = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        roll     = 1'b0;
        new_game = 1'b0;
        dice1_in = 3'd3;
        dice2_in = 3'd4;

        // Reset with roll toggling: everything held at zero.
        repeat (6) begin
            @(negedge clk);
            roll = ~roll;
        end
        check("rst.sum",   int'(sum_out),   0);
        check("rst.point", int'(point_out), 0);
        check("rst.state", int'(state_out), 0);
        check("rst.win",   int'(win),       0);
        check("rst.lose",  int'(lose),      0);
        check("rst.bad",   int'(bad_roll),  0);
        @(negedge clk);
        roll = 1'b0;
        rst  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rst.release%0d.bad", i), int'(bad_roll), 0);
        end
        check("rst.release.state", int'(state_out), 0);
        check("rst.release.sum",   int'(sum_out),   0);

        // Vector table: {new_game?, die1, die2, expected sum/point/state/bad/count}.
        vecs.push_back(mkv(0, 3, 4, mke(7, 0, 2, 0, 1)));   // natural 7
        vecs.push_back(mkv(0, 1, 1, mke(7, 0, 2, 0, 1)));   // ignored in WIN
        vecs.push_back(mkv(1, 1, 1, mke(0, 0, 0, 0, 0)));
        vecs.push_back(mkv(0, 2, 2, mke(4, 4, 1, 0, 1)));   // point 4
        vecs.push_back(mkv(0, 3, 3, mke(6, 4, 1, 0, 2)));
        vecs.push_back(mkv(0, 1, 3, mke(4, 4, 2, 0, 3)));   // point made
        vecs.push_back(mkv(1, 1, 1, mke(0, 0, 0, 0, 0)));
        vecs.push_back(mkv(0, 5, 5, mke(10, 10, 1, 0, 1)));
        vecs.push_back(mkv(0, 6, 1, mke(7, 10, 3, 0, 2)));  // seven-out
        vecs.push_back(mkv(1, 1, 1, mke(0, 0, 0, 0, 0)));
        vecs.push_back(mkv(0, 7, 2, mke(0, 0, 0, 1, 0)));   // face 7 illegal
        vecs.push_back(mkv(0, 0, 3, mke(0, 0, 0, 1, 0)));   // face 0 illegal
        vecs.push_back(mkv(0, 6, 5, mke(11, 0, 2, 0, 1)));  // natural 11
        vecs.push_back(mkv(1, 1, 1, mke(0, 0, 0, 0, 0)));
        vecs.push_back(mkv(0, 1, 2, mke(3, 0, 3, 0, 1)));   // craps 3
        vecs.push_back(mkv(1, 1, 1, mke(0, 0, 0, 0, 0)));
        vecs.push_back(mkv(0, 6, 6, mke(12, 0, 3, 0, 1)));  // craps 12
        vecs.push_back(mkv(1, 1, 1, mke(0, 0, 0, 0, 0)));
        vecs.push_back(mkv(0, 4, 5, mke(9, 9, 1, 0, 1)));
        vecs.push_back(mkv(0, 7, 7, mke(9, 9, 1, 1, 1)));   // illegal in POINT
        vecs.push_back(mkv(0, 4, 3, mke(7, 9, 3, 0, 2)));
        vecs.push_back(mkv(0, 0, 0, mke(7, 9, 3, 0, 2)));   // no bad check in LOSE
        vecs.push_back(mkv(1, 1, 1, mke(0, 0, 0, 0, 0)));

        for (int i = 0; i < vecs.size(); i++)
            apply_vec($sformatf("vec%0d", i), vecs[i]);

        // Mid-game reset aborts asynchronously.
        apply_vec("pre_abort", mkv(0, 2, 2, mke(4, 4, 1, 0, 1)));
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort.sum",   int'(sum_out),   0);
        check("abort.point", int'(point_out), 0);
        check("abort.state", int'(state_out), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Simultaneous roll and new_game from POINT: new_game wins, no bad_roll.
        apply_vec("pre_coll", mkv(0, 2, 2, mke(4, 4, 1, 0, 1)));
        @(negedge clk);
        dice1_in = 3'd7;
        dice2_in = 3'd7;
        roll     = 1'b1;
        new_game = 1'b1;
        sb_q.push_back(mke(0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_sb("coll");
        @(negedge clk);
        check("coll.bad_next", int'(bad_roll), 0);
        roll     = 1'b0;
        new_game = 1'b0;
        repeat (4) @(negedge clk);

        // Roll held high for 20 cycles: a second evaluation of 2+2 would WIN.
        @(negedge clk);
        dice1_in = 3'd2;
        dice2_in = 3'd2;
        roll     = 1'b1;
        sb_q.push_back(mke(4, 4, 1, 0, 1));
        repeat (20) @(negedge clk);
        compare_sb("hold");
        roll = 1'b0;
        repeat (4) @(negedge clk);

        check("sb.drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
